// File: rtl/sequenciador_movimentos.sv
// Reads move bytes from a RAM and runs each one through the motor driver; idle/done/error wait for iniciar.
// One move takes 4 cycles plus the motor wait (at most TIMEOUT_CICLOS cycles); iniciar is ignored while ocupado.
module sequenciador_movimentos #(
    parameter int ADDR_W         = 5,
    parameter int TIMEOUT_CICLOS = 50_000_000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic [ADDR_W:0]   num_movimentos,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_dado,
    output logic              motor_partida,
    output logic [2:0]        motor_face,
    output logic [1:0]        motor_sentido,
    input  logic              motor_fim,
    output logic              ocupado,
    output logic              pronto,
    output logic              erro,
    output logic [ADDR_W:0]   db_executados,
    output logic [3:0]        db_estado
);
    localparam int CW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam logic [CW-1:0]     CNT_MAX  = CW'(TIMEOUT_CICLOS - 1);
    localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   EXEC_ONE = (ADDR_W + 1)'(1);

    typedef enum logic [3:0] {
        INICIAL      = 4'd0,
        PREPARA      = 4'd1,
        LE_MEM       = 4'd2,
        DECODIFICA   = 4'd3,
        ACIONA       = 4'd4,
        ESPERA_MOTOR = 4'd5,
        PROXIMO      = 4'd6,
        FIM          = 4'd7,
        ERRO         = 4'd8
    } estado_t;

    estado_t          estado;
    logic [CW-1:0]    cnt;
    logic [ADDR_W:0]  total_movimentos;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado           <= INICIAL;
            mem_addr         <= '0;
            motor_partida    <= 1'b0;
            motor_face       <= '0;
            motor_sentido    <= '0;
            ocupado          <= 1'b0;
            pronto           <= 1'b0;
            erro             <= 1'b0;
            db_executados    <= '0;
            cnt              <= '0;
            total_movimentos <= '0;
        end else begin
            motor_partida <= 1'b0;
            pronto        <= 1'b0;
            case (estado)
                INICIAL: begin
                    if (iniciar) begin
                        estado  <= PREPARA;
                        ocupado <= 1'b1;
                    end
                end
                PREPARA: begin
                    mem_addr         <= '0;
                    db_executados    <= '0;
                    cnt              <= '0;
                    total_movimentos <= num_movimentos;
                    if (num_movimentos == '0) begin
                        estado  <= FIM;
                        ocupado <= 1'b0;
                        pronto  <= 1'b1;
                    end else begin
                        estado <= LE_MEM;
                    end
                end
                LE_MEM: estado <= DECODIFICA;
                DECODIFICA: begin
                    if (mem_dado == 8'hFF) begin
                        estado  <= FIM;
                        ocupado <= 1'b0;
                        pronto  <= 1'b1;
                    end else if (mem_dado[2:0] > 3'd5 || mem_dado[4:3] == 2'b11 || mem_dado[7:5] != 3'b000) begin
                        estado  <= ERRO;
                        ocupado <= 1'b0;
                        erro    <= 1'b1;
                    end else begin
                        motor_face    <= mem_dado[2:0];
                        motor_sentido <= mem_dado[4:3];
                        motor_partida <= 1'b1;
                        estado        <= ACIONA;
                    end
                end
                ACIONA: begin
                    cnt    <= '0;
                    estado <= ESPERA_MOTOR;
                end
                ESPERA_MOTOR: begin
                    // completion takes priority over a timeout in the same cycle
                    if (motor_fim) begin
                        estado <= PROXIMO;
                    end else if (cnt == CNT_MAX) begin
                        estado  <= ERRO;
                        ocupado <= 1'b0;
                        erro    <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                PROXIMO: begin
                    db_executados <= db_executados + EXEC_ONE;
                    // the last address also ends the run so mem_addr never wraps
                    if ((db_executados + EXEC_ONE) == total_movimentos || (&mem_addr)) begin
                        estado  <= FIM;
                        ocupado <= 1'b0;
                        pronto  <= 1'b1;
                    end else begin
                        mem_addr <= mem_addr + ADDR_ONE;
                        estado   <= LE_MEM;
                    end
                end
                FIM: begin
                    if (iniciar) begin
                        estado  <= PREPARA;
                        ocupado <= 1'b1;
                    end
                end
                ERRO: begin
                    if (iniciar) begin
                        estado  <= PREPARA;
                        ocupado <= 1'b1;
                        erro    <= 1'b0;
                    end
                end
                default: begin
                    estado  <= INICIAL;
                    ocupado <= 1'b0;
                    erro    <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        case (estado)
            INICIAL, PREPARA, LE_MEM, DECODIFICA, ACIONA,
            ESPERA_MOTOR, PROXIMO, FIM, ERRO: db_estado = estado;
            default:                          db_estado = 4'hF;
        endcase
    end
endmodule

// File: doc/sequenciador_movimentos.md
SEQUENCIADOR_MOVIMENTOS -- requirements
Module: sequenciador_movimentos

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, move-memory address width (up to 32 moves).
REQ-002 SHALL have parameter TIMEOUT_CICLOS, default 50_000_000, max cycles waiting for motor_fim per move.
REQ-003 SHALL have port clock, input, 1, single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port iniciar, input, 1, start request, level-sampled in INICIAL/FIM/ERRO.
REQ-006 SHALL have port num_movimentos, input, ADDR_W+1, number of stored moves, captured at start.
REQ-007 SHALL have port mem_addr, output, ADDR_W, read address to move RAM.
REQ-008 SHALL have port mem_dado, input, 8, RAM read data, valid one cycle after mem_addr changes.
REQ-009 SHALL have port motor_partida, output, 1, one-cycle start pulse to motor driver.
REQ-010 SHALL have port motor_face, output, 3, face code 0..5 (U,D,F,B,L,R), held from decode until next decode.
REQ-011 SHALL have port motor_sentido, output, 2, 00 = 90 cw, 01 = 90 ccw, 10 = 180.
REQ-012 SHALL have port motor_fim, input, 1, driver completion pulse/level.
REQ-013 SHALL have ports ocupado (1), pronto (1), erro (1), outputs: busy level, one-cycle done pulse, sticky error.
REQ-014 SHALL have port db_executados, output, ADDR_W+1, count of completed moves.
REQ-015 SHALL have port db_estado, output, 4, current state code.

Function
REQ-016 SHALL implement states with db_estado codes: INICIAL 0, PREPARA 1, LE_MEM 2, DECODIFICA 3, ACIONA 4, ESPERA_MOTOR 5, PROXIMO 6, FIM 7, ERRO 8; unused codes SHALL go to INICIAL, db_estado = 4'hF.
REQ-017 INICIAL: iniciar=1 -> PREPARA, else stay.
REQ-018 PREPARA: clear mem_addr, db_executados, timeout counter; latch num_movimentos; if latched value = 0 -> FIM, else -> LE_MEM.
REQ-019 LE_MEM: hold mem_addr one cycle -> DECODIFICA (covers 1-cycle RAM latency).
REQ-020 DECODIFICA: latch mem_dado; 8'hFF -> FIM; bits[2:0] > 5 or bits[4:3] = 11 or bits[7:5] != 0 -> ERRO; else load motor_face = bits[2:0], motor_sentido = bits[4:3] -> ACIONA.
REQ-021 ACIONA: motor_partida = 1 for exactly this cycle; clear timeout counter -> ESPERA_MOTOR.
REQ-022 ESPERA_MOTOR: motor_fim sampled only here; motor_fim=1 -> PROXIMO; counter reaching TIMEOUT_CICLOS-1 without motor_fim -> ERRO; motor_fim in same cycle as timeout -> PROXIMO (completion wins).
REQ-023 PROXIMO: db_executados += 1, mem_addr += 1; if db_executados+1 = latched count -> FIM, else -> LE_MEM.
REQ-024 mem_addr SHALL NOT wrap within a run; count 2^ADDR_W ends in FIM after address 2^ADDR_W-1.
REQ-025 FIM: pronto = 1 on the first FIM cycle only; iniciar=1 -> PREPARA, else stay.
REQ-026 ERRO: erro = 1 held; iniciar=1 -> PREPARA (erro clears in PREPARA).
REQ-027 ocupado SHALL be 1 in states PREPARA through PROXIMO, 0 in INICIAL, FIM, ERRO.
REQ-028 iniciar while ocupado = 1 SHALL be ignored; num_movimentos changes mid-run SHALL be ignored.
REQ-029 Motor-side outputs SHALL be registered (no combinational path from mem_dado or motor_fim to outputs).

Reset
REQ-030 reset=1 SHALL force INICIAL asynchronously in any state, including ESPERA_MOTOR mid-move.
REQ-031 Reset values: mem_addr 0, motor_partida 0, motor_face 0, motor_sentido 0, ocupado 0, pronto 0, erro 0, db_executados 0, db_estado 0, internal counters 0.

Verification
REQ-032 RAM {8'h00, 8'h0A, 8'h15}, num_movimentos=3, motor_fim 10 cycles after each partida -> partida pulses with (face,sentido) = (0,00),(2,01),(5,10); db_executados=3; single pronto pulse; final state FIM.
REQ-033 num_movimentos=0, iniciar pulse -> PREPARA then FIM, no motor_partida, pronto pulse, db_executados=0.
REQ-034 RAM {8'h01, 8'hFF, 8'h02}, num_movimentos=3 -> one partida (face 1), FIM after decoding 8'hFF, db_executados=1.
REQ-035 RAM {8'h06} -> ERRO, erro=1, no partida; then iniciar with valid RAM -> erro clears, run completes.
REQ-036 TIMEOUT_CICLOS=20, motor_fim never asserted -> ERRO 20 cycles after partida; separately motor_fim on cycle 20 -> PROXIMO.
REQ-037 reset asserted during ESPERA_MOTOR -> same-cycle INICIAL, all outputs at REQ-031 values; iniciar held high during a run -> no restart until FIM.
